// File: rtl/win_rd_ctl_pkg.sv
// Shared layer-control package: FSM state encodings, layer size
// codes, per-layer feature-map dimensions and address widths.
package win_rd_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] LAYER_160  = 2'd0;
    localparam logic [1:0] LAYER_320  = 2'd1;
    localparam logic [1:0] LAYER_640  = 2'd2;
    localparam logic [1:0] LAYER_RSVD = 2'd3;

    localparam int unsigned W_L0 = 160;
    localparam int unsigned H_L0 = 90;
    localparam int unsigned W_L1 = 320;
    localparam int unsigned H_L1 = 180;
    localparam int unsigned W_L2 = 640;
    localparam int unsigned H_L2 = 360;

    localparam int ROW_W = 9;
    localparam int COL_W = 10;

    function automatic logic layer_ok(input logic [1:0] l);
        return l != LAYER_RSVD;
    endfunction

endpackage

// File: rtl/win_rd_ctl_tap_cnt.sv
// win_tap_cnt: kx -> ky -> ocol -> orow counter chain for the
// 3x3 window walk. Ports: clr_i, adv_i, w_i/h_i in; counters, last_o out.
module win_tap_cnt
    import win_rd_ctl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic [COL_W-1:0] w_i,
    input  logic [ROW_W-1:0] h_i,
    output logic [1:0]       kx_o,
    output logic [1:0]       ky_o,
    output logic [COL_W-1:0] ocol_o,
    output logic [ROW_W-1:0] orow_o,
    output logic             last_o
);

    logic [1:0]       kx_q, kx_d;
    logic [1:0]       ky_q, ky_d;
    logic [COL_W-1:0] ocol_q, ocol_d;
    logic [ROW_W-1:0] orow_q, orow_d;

    logic kx_wrap, ky_wrap, col_wrap, row_wrap;

    assign kx_wrap  = (kx_q == 2'd2);
    assign ky_wrap  = (ky_q == 2'd2);
    assign col_wrap = (ocol_q == w_i - COL_W'(1));
    assign row_wrap = (orow_q == h_i - ROW_W'(1));

    always_comb begin
        kx_d   = kx_q;
        ky_d   = ky_q;
        ocol_d = ocol_q;
        orow_d = orow_q;
        if (clr_i) begin
            kx_d   = '0;
            ky_d   = '0;
            ocol_d = '0;
            orow_d = '0;
        end else if (adv_i) begin
            if (!kx_wrap) begin
                kx_d = kx_q + 2'd1;
            end else begin
                kx_d = '0;
                if (!ky_wrap) begin
                    ky_d = ky_q + 2'd1;
                end else begin
                    ky_d = '0;
                    if (!col_wrap) begin
                        ocol_d = ocol_q + COL_W'(1);
                    end else begin
                        ocol_d = '0;
                        orow_d = row_wrap ? '0
                                          : orow_q + ROW_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kx_q   <= '0;
            ky_q   <= '0;
            ocol_q <= '0;
            orow_q <= '0;
        end else begin
            kx_q   <= kx_d;
            ky_q   <= ky_d;
            ocol_q <= ocol_d;
            orow_q <= orow_d;
        end
    end

    assign kx_o   = kx_q;
    assign ky_o   = ky_q;
    assign ocol_o = ocol_q;
    assign orow_o = orow_q;
    assign last_o = kx_wrap & ky_wrap & col_wrap & row_wrap;

endmodule

// File: rtl/win_rd_ctl.sv
// Feature-map 3x3 window read controller: on start walks every output
// pixel's taps, emitting row/col/tap/pad with a valid/ready handshake.
// Ports: start/layer in; rd_valid/rd_row/rd_col/tap/pad/pix_last,
// rd_ready in; done/busy status out. Dims default to package values.
module win_rd_ctl
    import win_rd_ctl_pkg::*;
#(
    parameter int unsigned W0 = W_L0,
    parameter int unsigned H0 = H_L0,
    parameter int unsigned W1 = W_L1,
    parameter int unsigned H1 = H_L1,
    parameter int unsigned W2 = W_L2,
    parameter int unsigned H2 = H_L2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       layer,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [ROW_W-1:0] rd_row,
    output logic [COL_W-1:0] rd_col,
    output logic [3:0]       tap,
    output logic             pad,
    output logic             pix_last,
    output logic             done,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [COL_W-1:0] w_q, w_d;
    logic [ROW_W-1:0] h_q, h_d;

    logic             clr;
    logic             hs;
    logic             last;
    logic [1:0]       kx, ky;
    logic [COL_W-1:0] ocol;
    logic [ROW_W-1:0] orow;

    logic signed [ROW_W:0]   r;
    logic signed [COL_W:0]   c;
    logic                    oob;
    logic [3:0]              tap_idx;

    assign rd_valid = (state_q == ST_RUN);
    assign hs       = rd_valid & rd_ready;

    win_tap_cnt u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .adv_i  (hs),
        .w_i    (w_q),
        .h_i    (h_q),
        .kx_o   (kx),
        .ky_o   (ky),
        .ocol_o (ocol),
        .orow_o (orow),
        .last_o (last)
    );

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        clr     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && layer_ok(layer)) begin
                    state_d = ST_RUN;
                    clr     = 1'b1;
                    unique case (layer)
                        LAYER_160: begin
                            w_d = COL_W'(W0);
                            h_d = ROW_W'(H0);
                        end
                        LAYER_320: begin
                            w_d = COL_W'(W1);
                            h_d = ROW_W'(H1);
                        end
                        default: begin
                            w_d = COL_W'(W2);
                            h_d = ROW_W'(H2);
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (hs && last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            w_q     <= '0;
            h_q     <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
        end
    end

    // One extra sign bit covers the -1 and H/W overhang of the window.
    assign r = $signed({1'b0, orow})
             + $signed({{(ROW_W-1){1'b0}}, ky})
             - $signed((ROW_W+1)'(1));
    assign c = $signed({1'b0, ocol})
             + $signed({{(COL_W-1){1'b0}}, kx})
             - $signed((COL_W+1)'(1));

    assign oob = (r < 0)
              || (r > $signed({1'b0, h_q}) - $signed((ROW_W+1)'(1)))
              || (c < 0)
              || (c > $signed({1'b0, w_q}) - $signed((COL_W+1)'(1)));

    assign tap_idx = ({2'b00, ky} * 4'd3) + {2'b00, kx};

    // Outputs are gated by rd_valid so reset/idle drives all zeros.
    assign rd_row   = (rd_valid && !oob) ? r[ROW_W-1:0] : '0;
    assign rd_col   = (rd_valid && !oob) ? c[COL_W-1:0] : '0;
    assign tap      = rd_valid ? tap_idx : 4'd0;
    assign pad      = rd_valid & oob;
    assign pix_last = rd_valid & (tap_idx == 4'd8);
    assign done     = (state_q == ST_DONE);
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_win_rd_ctl.sv
// Scoreboard bench for win_rd_ctl with scaled-down map dims so full
// passes fit; random backpressure, ignored starts and mid-pass reset.
module tb_win_rd_ctl;
    import win_rd_ctl_pkg::*;

    localparam int TW0 = 16, TH0 = 9;
    localparam int TW1 = 32, TH1 = 18;
    localparam int TW2 = 64, TH2 = 36;

    logic       clk = 0;
    logic       rst = 1;
    logic       start = 0;
    logic [1:0] layer = 0;
    logic       rd_ready = 1;
    logic       rd_valid;
    logic [8:0] rd_row;
    logic [9:0] rd_col;
    logic [3:0] tap;
    logic       pad;
    logic       pix_last;
    logic       done;
    logic       busy;

    win_rd_ctl #(
        .W0(TW0), .H0(TH0),
        .W1(TW1), .H1(TH1),
        .W2(TW2), .H2(TH2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .layer    (layer),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_row   (rd_row),
        .rd_col   (rd_col),
        .tap      (tap),
        .pad      (pad),
        .pix_last (pix_last),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int col;
        int tp;
        bit pd;
        bit lst;
        bit eop;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    bit   exp_done = 0;
    bit   rnd_ready = 0;

    task automatic chk(input string nm, input int act,
                       input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    // Reference: enumerate output pixels and taps directly.
    task automatic push_pass(input int l);
        int w, h;
        exp_t e;
        w = (l == 0) ? TW0 : (l == 1) ? TW1 : TW2;
        h = (l == 0) ? TH0 : (l == 1) ? TH1 : TH2;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                for (int t = 0; t < 9; t++) begin
                    int rr, cc;
                    rr = y + t / 3 - 1;
                    cc = x + t % 3 - 1;
                    e.pd  = rr < 0 || rr >= h || cc < 0 || cc >= w;
                    e.row = e.pd ? 0 : rr;
                    e.col = e.pd ? 0 : cc;
                    e.tp  = t;
                    e.lst = (t == 8);
                    e.eop = (y == h-1) && (x == w-1) && (t == 8);
                    q.push_back(e);
                end
    endtask

    initial forever begin
        @(posedge clk);
        #1 rd_ready = rnd_ready ? ($urandom_range(0, 2) != 0)
                                : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (exp_done) begin
                chk("done_after_last", {done, rd_valid}, 2);
                exp_done = 0;
            end else if (done) begin
                chk("unexpected_done", 1, 0);
            end
            if (done) done_cnt++;
            if (rd_valid) begin
                if (q.size() == 0) begin
                    chk("tap_without_expect", 1, 0);
                end else begin
                    exp_t e;
                    e = q[0];
                    n_cmp++;
                    if (rd_row != e.row || rd_col != e.col ||
                        tap != e.tp || pad != e.pd ||
                        pix_last != e.lst) begin
                        n_bad++;
                        $display({"FAIL tap: got r%0d c%0d t%0d ",
                                  "p%0d l%0d want r%0d c%0d t%0d ",
                                  "p%0d l%0d"},
                                 rd_row, rd_col, tap, pad, pix_last,
                                 e.row, e.col, e.tp, e.pd, e.lst);
                    end
                    if (rd_ready) begin
                        void'(q.pop_front());
                        if (e.eop) exp_done = 1;
                    end
                end
            end
        end
    end

    task automatic pulse_start(input logic [1:0] l);
        @(posedge clk);
        #1 start = 1;
        layer = l;
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int d0;
        bit hit;
        d0 = done_cnt;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(posedge clk);
            if (done_cnt != d0) hit = 1;
        end
        chk({nm, "_done_seen"}, hit, 1);
        @(negedge clk);
        chk({nm, "_idle_busy"}, busy, 0);
        chk({nm, "_queue_empty"}, q.size(), 0);
    endtask

    task automatic run_pass(input int l, input bit rr,
                            input string nm);
        int taps;
        taps = 9 * ((l == 0) ? TW0*TH0 : (l == 1) ? TW1*TH1
                                                  : TW2*TH2);
        rnd_ready = rr;
        push_pass(l);
        pulse_start(2'(l));
        @(negedge clk);
        chk({nm, "_first_valid"}, rd_valid, 1);
        chk({nm, "_busy"}, busy, 1);
        wait_done(taps * 4 + 100, nm);
    endtask

    initial begin
        int d0;
        #12;
        chk("reset_outputs",
            {rd_valid, rd_row, rd_col, tap, pad, pix_last, done, busy},
            0);
        @(posedge clk);
        #1 rst = 0;

        run_pass(0, 0, "l0_full");
        run_pass(0, 1, "l0_stall");

        rnd_ready = 0;
        push_pass(2);
        pulse_start(2'd2);
        repeat (50) @(posedge clk);
        #1 start = 1;
        layer = 2'd1;
        @(posedge clk);
        #1 start = 0;
        wait_done(9*TW2*TH2 + 200, "l2_restart_ign");

        d0 = done_cnt;
        pulse_start(2'd3);
        repeat (5) @(negedge clk);
        chk("rsvd_no_valid", rd_valid, 0);
        chk("rsvd_no_busy", busy, 0);
        chk("rsvd_no_done", done_cnt, d0);

        rnd_ready = 1;
        push_pass(1);
        pulse_start(2'd1);
        repeat (300) @(posedge clk);
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("async_rst_outputs",
            {rd_valid, rd_row, rd_col, tap, pad, pix_last, done, busy},
            0);
        q.delete();
        exp_done = 0;
        @(posedge clk);
        #1;
        chk("rst_held_idle", {rd_valid, busy}, 0);
        push_pass(1);
        rst = 0;
        start = 1;
        layer = 2'd1;
        @(posedge clk);
        #1 start = 0;
        @(negedge clk);
        chk("post_rst_first_valid", rd_valid, 1);
        wait_done(9*TW1*TH1*4 + 100, "l1_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
